// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin request/response arbiter in front of a single-ported data memory
module dmem_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_rq0_valid,
  output logic              o_rq0_ready,
  input  logic              i_rq0_we,
  input  logic [ADDR_W-1:0] i_rq0_addr,
  input  logic [DATA_W-1:0] i_rq0_wdata,
  input  logic [2:0]        i_rq0_func3,
  output logic              o_rs0_valid,
  output logic [DATA_W-1:0] o_rs0_rdata,
  output logic              o_rs0_err,

  input  logic              i_rq1_valid,
  output logic              o_rq1_ready,
  input  logic              i_rq1_we,
  input  logic [ADDR_W-1:0] i_rq1_addr,
  input  logic [DATA_W-1:0] i_rq1_wdata,
  input  logic [2:0]        i_rq1_func3,
  output logic              o_rs1_valid,
  output logic [DATA_W-1:0] o_rs1_rdata,
  output logic              o_rs1_err,

  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [2:0]        o_mem_func3,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [2:0]        r_mem_func3;
  logic [1:0]        r_rs_valid;
  logic              r_rs_err;
  logic [DATA_W-1:0] r_rs_rdata;

  logic              w_idle;
  logic              w_any;
  logic              w_winner;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [2:0]        w_func3;
  logic              w_bad;

  // Rejects unsupported size/sign codes and, optionally, unaligned half/word accesses.
  function automatic logic f_bad(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a);
    logic ok;
    ok = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (CHECK_ALIGN) begin
      if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) ok = 1'b0;
      if (f3 == 3'd2 && a[1:0] != 2'b00) ok = 1'b0;
    end
    return ~ok;
  endfunction

  // With both ports contending, the one not served last wins.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_any    = i_rq0_valid | i_rq1_valid;
  assign w_winner = (i_rq0_valid & i_rq1_valid) ? ~r_last_grant : i_rq1_valid;

  assign o_rq0_ready = w_idle & w_any & ~w_winner;
  assign o_rq1_ready = w_idle & w_any &  w_winner;

  assign w_we    = w_winner ? i_rq1_we    : i_rq0_we;
  assign w_addr  = w_winner ? i_rq1_addr  : i_rq0_addr;
  assign w_wdata = w_winner ? i_rq1_wdata : i_rq0_wdata;
  assign w_func3 = w_winner ? i_rq1_func3 : i_rq0_func3;
  assign w_bad   = f_bad(w_we, w_func3, w_addr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_func3  <= '0;
      r_rs_valid   <= '0;
      r_rs_err     <= 1'b0;
      r_rs_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            if (w_bad) begin
              r_state    <= ST_RESP;
              r_rs_valid <= w_winner ? 2'b10 : 2'b01;
              r_rs_err   <= 1'b1;
              r_rs_rdata <= '0;
            end else begin
              r_state     <= ST_ACCESS;
              r_mem_read  <= ~w_we;
              r_mem_write <= w_we;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= w_wdata;
              r_mem_func3 <= w_func3;
            end
          end
        end
        ST_ACCESS: begin
          r_state     <= ST_RESP;
          r_rs_valid  <= r_owner ? 2'b10 : 2'b01;
          r_rs_err    <= 1'b0;
          r_rs_rdata  <= r_mem_write ? '0 : i_mem_rdata;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_mem_func3 <= '0;
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_last_grant <= r_owner;
          r_rs_valid   <= '0;
          r_rs_err     <= 1'b0;
          r_rs_rdata   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so an in-flight store never commits.
  assign o_mem_read  = r_mem_read  & ~i_rst;
  assign o_mem_write = r_mem_write & ~i_rst;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_func3 = r_mem_func3;

  assign o_rs0_valid = r_rs_valid[0];
  assign o_rs1_valid = r_rs_valid[1];
  assign o_rs0_err   = r_rs_valid[0] & r_rs_err;
  assign o_rs1_err   = r_rs_valid[1] & r_rs_err;
  assign o_rs0_rdata = r_rs_valid[0] ? r_rs_rdata : '0;
  assign o_rs1_rdata = r_rs_valid[1] ? r_rs_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a byte-level memory model
module tb_dmem_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       rq_valid;
  logic [1:0]       rq_ready;
  logic [1:0]       rq_we;
  logic [1:0][7:0]  rq_addr;
  logic [1:0][31:0] rq_wdata;
  logic [1:0][2:0]  rq_func3;
  logic [1:0]       rs_valid;
  logic [1:0][31:0] rs_rdata;
  logic [1:0]       rs_err;
  logic             mem_read;
  logic             mem_write;
  logic [7:0]       mem_addr;
  logic [31:0]      mem_wdata;
  logic [2:0]       mem_func3;
  logic [31:0]      mem_rdata;

  logic [7:0] dev_mem [256];
  logic [7:0] ref_mem [256];
  int n_checks;
  int n_pass;

  dmem_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_rq0_valid(rq_valid[0]), .o_rq0_ready(rq_ready[0]), .i_rq0_we(rq_we[0]),
    .i_rq0_addr(rq_addr[0]), .i_rq0_wdata(rq_wdata[0]), .i_rq0_func3(rq_func3[0]),
    .o_rs0_valid(rs_valid[0]), .o_rs0_rdata(rs_rdata[0]), .o_rs0_err(rs_err[0]),
    .i_rq1_valid(rq_valid[1]), .o_rq1_ready(rq_ready[1]), .i_rq1_we(rq_we[1]),
    .i_rq1_addr(rq_addr[1]), .i_rq1_wdata(rq_wdata[1]), .i_rq1_func3(rq_func3[1]),
    .o_rs1_valid(rs_valid[1]), .o_rs1_rdata(rs_rdata[1]), .o_rs1_err(rs_err[1]),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_func3(mem_func3), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Narrows a little-endian 4-byte window to the access size, sign- or zero-extending.
  function automatic logic [31:0] shape(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd4:    return {24'd0, raw[7:0]};
      3'd5:    return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb begin
    logic [31:0] raw;
    raw = '0;
    for (int k = 0; k < 4; k++) raw[8*k +: 8] = dev_mem[mem_addr + 8'(k)];
    mem_rdata = shape(raw, mem_func3);
  end

  always @(posedge clk) begin
    if (mem_write)
      for (int k = 0; k < nbytes(mem_func3); k++) dev_mem[mem_addr + 8'(k)] = mem_wdata[8*k +: 8];
  end

  function automatic logic model_bad(input logic we, input logic [2:0] f3, input logic [7:0] a);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    return (int'(a) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] a, input logic [2:0] f3);
    logic [31:0] raw;
    for (int k = 0; k < 4; k++) raw[8*k +: 8] = ref_mem[a + 8'(k)];
    return shape(raw, f3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Issues one request on port p starting at a negedge; returns at the negedge of the earliest next acceptance.
  task automatic req(input int p, input logic we, input logic [7:0] a, input logic [31:0] d,
                     input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int w;
    logic bad;
    logic [31:0] exp_rd;
    bad    = model_bad(we, f3, a);
    exp_rd = (bad || we) ? 32'd0 : model_load(a, f3);
    rd = '0;
    er = 1'b0;
    rq_we[p] = we; rq_addr[p] = a; rq_wdata[p] = d; rq_func3[p] = f3; rq_valid[p] = 1'b1;
    #1;
    w = 0;
    while (rq_ready[p] !== 1'b1 && w < 16) begin
      @(negedge clk); #1;
      w++;
    end
    chk("accept_wait", 32'(w), 32'd0);
    if (rq_ready[p] === 1'b1) begin
      @(posedge clk); #1;
      rq_valid[p] = 1'b0;
      @(negedge clk); #1;
      if (bad) begin
        chkb("err_no_read", mem_read, 1'b0);
        chkb("err_no_write", mem_write, 1'b0);
        chkb("err_rs_valid", rs_valid[p], 1'b1);
      end else begin
        chkb("mem_read", mem_read, ~we);
        chkb("mem_write", mem_write, we);
        chk("mem_addr", 32'(mem_addr), 32'(a));
        chk("mem_func3", 32'(mem_func3), 32'(f3));
        if (we) chk("mem_wdata", mem_wdata, d);
        chkb("early_rs", rs_valid[p], 1'b0);
        @(negedge clk); #1;
        chkb("rs_valid", rs_valid[p], 1'b1);
        chkb("rs_idle_read", mem_read | mem_write, 1'b0);
      end
      chkb("rs_other", rs_valid[1-p], 1'b0);
      chkb("rs_err", rs_err[p], bad);
      chk("rs_rdata", rs_rdata[p], exp_rd);
      rd = rs_rdata[p];
      er = rs_err[p];
      if (!bad && we)
        for (int k = 0; k < nbytes(f3); k++) ref_mem[a + 8'(k)] = d[8*k +: 8];
    end else begin
      rq_valid[p] = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic er;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    rq_valid = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0; rq_func3 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chkb("rst_mem_read", mem_read, 1'b0);
    chkb("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rs_valid", 32'(rs_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_ready", 32'(rq_ready), 32'd0);
    chk("idle_rs", 32'(rs_valid), 32'd0);

    // Contention from reset: port 0 first, then strict alternation.
    rq_we = '0;
    rq_addr[0] = 8'h10; rq_func3[0] = 3'd2;
    rq_addr[1] = 8'h44; rq_func3[1] = 3'd2;
    rq_valid = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      int g;
      g = k % 2;
      chkb("rr_ready0", rq_ready[0], g == 0);
      chkb("rr_ready1", rq_ready[1], g == 1);
      @(negedge clk); #1;
      chk("rr_busy_ready", 32'(rq_ready), 32'd0);
      @(negedge clk); #1;
      chkb("rr_rs_win", rs_valid[g], 1'b1);
      chkb("rr_rs_lose", rs_valid[1-g], 1'b0);
      chk("rr_rdata", rs_rdata[g], model_load(rq_addr[g], 3'd2));
      @(negedge clk); #1;
    end
    rq_valid = 2'b00;
    @(negedge clk);

    req(0, 1'b1, 8'h10, 32'hDEADBEEF, 3'd2, rd, er);
    chk("t1_sw_rdata", rd, 32'd0);
    req(0, 1'b0, 8'h10, 32'd0, 3'd2, rd, er);
    chk("t1_lw", rd, 32'hDEADBEEF);

    req(1, 1'b0, 8'h06, 32'd0, 3'd2, rd, er);
    chkb("t3_lw_mis", er, 1'b1);
    req(1, 1'b0, 8'h03, 32'd0, 3'd1, rd, er);
    chkb("t3_lh_mis", er, 1'b1);
    req(1, 1'b1, 8'h20, 32'h55, 3'd4, rd, er);
    chkb("t3_sb_f4", er, 1'b1);

    req(0, 1'b1, 8'h20, 32'h00000080, 3'd0, rd, er);
    req(0, 1'b0, 8'h20, 32'd0, 3'd0, rd, er);
    chk("t4_lb", rd, 32'hFFFFFF80);
    req(1, 1'b0, 8'h20, 32'd0, 3'd4, rd, er);
    chk("t4_lbu", rd, 32'h00000080);

    // Reset lands on the ACCESS cycle of a store.
    rq_we[0] = 1'b1; rq_addr[0] = 8'h30; rq_wdata[0] = 32'h12345678; rq_func3[0] = 3'd2;
    rq_valid[0] = 1'b1;
    #1;
    chkb("t5_ready", rq_ready[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    rq_valid[0] = 1'b0;
    @(negedge clk); #1;
    chkb("t5_write_gated", mem_write, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("t5_no_rs", 32'(rs_valid), 32'd0);
    @(negedge clk);
    req(0, 1'b0, 8'h30, 32'd0, 3'd2, rd, er);
    chk("t5_word_kept", dev_mem[8'h30] == ref_mem[8'h30] ? rd : 32'hBAD0BAD0, model_load(8'h30, 3'd2));

    // Port 0 pulses valid only while port 1 is busy.
    rq_we[1] = 1'b0; rq_addr[1] = 8'h40; rq_func3[1] = 3'd2; rq_valid[1] = 1'b1;
    #1;
    chkb("t6_ready1", rq_ready[1], 1'b1);
    @(posedge clk); #1;
    rq_valid[1] = 1'b0;
    rq_we[0] = 1'b0; rq_addr[0] = 8'h10; rq_func3[0] = 3'd2; rq_valid[0] = 1'b1;
    chkb("t6_ready0_busy", rq_ready[0], 1'b0);
    @(posedge clk); #1;
    rq_valid[0] = 1'b0;
    @(negedge clk); #1;
    chkb("t6_rs1", rs_valid[1], 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chkb("t6_no_rs0", rs_valid[0], 1'b0);
      chkb("t6_no_strobe", mem_read | mem_write, 1'b0);
    end

    for (int i = 0; i < 150; i++) begin
      int p;
      logic we;
      logic [7:0] a;
      logic [2:0] f3;
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      f3 = 3'($urandom_range(0, 7));
      req(p, we, a, $urandom, f3, rd, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
